load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the word-addressed data-memory port. Accepts load/store requests
//  from the core's MEM stage over a valid/ready handshake and drives
//  mem_access_addr/mem_write_data/mem_read/mem_write_en.
//  Byte stores to the 16-bit-wide memory are done as read-modify-write.
//  Sits between the pipeline MEM stage and the 256x16 data memory.
// PARAMETERS
//  ADDR_W  16  byte-address width; memory word index = addr[8:1]
//  DATA_W  16  data width; fixed at 16 (two bytes per word)
// PORTS
//  clk              in   1       single clock, all state on posedge
//  rst              in   1       synchronous, active-high reset
//  req_valid        in   1       request present
//  req_ready        out  1       LSU idle, can accept
//  req_op           in   2       00=LW 01=SW 10=LB 11=SB
//  req_addr         in   ADDR_W  byte address
//  req_wdata        in   DATA_W  store data; SB uses [7:0]
//  resp_valid       out  1       one-cycle completion pulse
//  resp_rdata       out  DATA_W  load result
//  resp_err         out  1       misaligned access (see CONFIGURATION)
//  mem_access_addr  out  ADDR_W  to memory
//  mem_write_data   out  DATA_W  to memory
//  mem_read         out  1       to memory; read data is combinational in same cycle
//  mem_write_en     out  1       to memory; written at posedge while high
//  mem_read_data    in   DATA_W  from memory
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0;
//    mem_read=0; mem_write_en=0; mem_access_addr=0; mem_write_data=0.
//  - Accept on req_valid&&req_ready at a posedge. req_ready=1 only in IDLE.
//    Op, addr and wdata are registered at accept; inputs are ignored afterwards.
//  - FSM: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
//    LW/LB: IDLE->RD->RESP.  SW: IDLE->WR->RESP.  SB: IDLE->RMW_RD->RMW_WR->RESP.
//    RESP->IDLE always.
//  - RD/RMW_RD: mem_read=1, addr=registered addr; mem_read_data is captured at the
//    end of that cycle.
//  - WR: mem_write_en=1, mem_write_data=wdata.
//  - RMW_WR: mem_write_en=1, merged word written. Little-endian merge:
//    addr[0]=0 replaces [7:0]; addr[0]=1 replaces [15:8]; other byte is unchanged.
//  - LB result: byte selected by addr[0] (0 selects [7:0], 1 selects [15:8]),
//    zero-extended to 16 bits.
//  - mem_read and mem_write_en are never high together.
//    In IDLE/RESP both are 0 and mem_access_addr and mem_write_data drive 0.
//  - Latency, accept edge to resp_valid high: LW/LB/SW 2 cycles; SB 3 cycles.
//    Throughput: one op per 3 cycles (4 for SB).
//  - resp_valid is high only in RESP, with no backpressure.
//    resp_rdata is updated only by loads and holds its value otherwise.
//    resp_err is valid with resp_valid and is 0 otherwise.
//  - rst mid-operation: next state is IDLE with no response. A write strobe high in the
//    cycle rst is sampled still commits (the memory has no reset). An SB reset in
//    RMW_RD is dropped and memory is unchanged.
//  - Addresses >= 512 alias via addr[8:1]; there is no bounds check.
// CONFIGURATION
//  LSU_ALIGN_CHECK_EN defined:
//    LW/SW with addr[0]=1 issue no memory strobes; IDLE->RESP with resp_err=1.
//    resp_rdata is unchanged. Latency is 1 cycle.
//  LSU_ALIGN_CHECK_EN undefined:
//    addr[0] is ignored for LW/SW (word access at addr[8:1]); resp_err is tied 0.
// TESTING
//  1. rst held 2 cycles -> all outputs at reset values; req_ready=1.
//  2. SW addr=0x0010 wdata=0xBEEF, then LW 0x0010 -> write strobe 1 cycle after accept;
//     resp_rdata=0xBEEF 2 cycles after LW accept.
//  3. Word 0x0010=0xBEEF; SB addr=0x0011 wdata=0x0042 -> RD then WR of 0x42EF;
//     resp_valid 3 cycles after accept. LB 0x0011 -> 0x0042; LB 0x0010 -> 0x00EF.
//  4. req_valid held high with back-to-back LW -> accepts exactly 3 cycles apart;
//     never both strobes high.
//  5. SW 0x0021: with LSU_ALIGN_CHECK_EN -> no write, resp_err=1 one cycle after accept;
//     without -> word 0x10 written, resp_err=0.
//  6. rst asserted during SB RMW_RD -> IDLE next cycle, no resp_valid, target word unchanged.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of the word-addressed data-memory port. Takes load/store
//   requests from the MEM stage over a valid/ready handshake and drives a
//   256x16 data memory whose read data is combinational. Byte stores are
//   done as a read-modify-write of the containing 16-bit word.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   req_valid/ready     request handshake; ready only while idle
//   req_op              00=LW 01=SW 10=LB 11=SB
//   req_addr/wdata      byte address and store data (SB uses [7:0])
//   resp_valid          one-cycle completion pulse
//   resp_rdata          load result, held between loads
//   resp_err            misaligned word access, valid with resp_valid
//   mem_*               memory port; word index is mem_access_addr[8:1]
//
// Configuration macro
//   LSU_ALIGN_CHECK_EN  when defined, LW/SW with addr[0]=1 skip the memory
//                       and respond next cycle with resp_err=1. When
//                       undefined, addr[0] is ignored for word accesses.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | ready for a request
// S_RD     | LW/LB read strobe; read data captured at end of cycle
// S_WR     | SW write strobe
// S_RMW_RD | SB read of containing word; merged word built at end of cycle
// S_RMW_WR | SB write of merged word
// S_RESP   | resp_valid pulse, then back to idle

module load_store_unit #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_access_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_read,
   output logic              mem_write_en,
   input  logic [DATA_W-1:0] mem_read_data
);

   localparam logic [1:0] OP_LW = 2'b00;
   localparam logic [1:0] OP_SW = 2'b01;
   localparam logic [1:0] OP_LB = 2'b10;
   localparam logic [1:0] OP_SB = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_RMW_RD,
      S_RMW_WR,
      S_RESP
   } state_t;

   state_t              state_q;
   logic                req_ready_q;
   logic                resp_valid_q;
   logic                resp_err_q;
   logic [DATA_W-1:0]   resp_rdata_q;
   logic                mem_read_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;

   // Only the parts of the request still needed after accept are kept.
   logic                is_lb_q;
   logic                sel_hi_q;
   logic [7:0]          sb_byte_q;

   logic                misalign_d;
   logic [DATA_W-1:0]   merge_word_d;
   logic [DATA_W-1:0]   load_byte_d;

`ifdef LSU_ALIGN_CHECK_EN
   assign misalign_d = ((req_op == OP_LW) || (req_op == OP_SW)) && req_addr[0];
`else
   assign misalign_d = 1'b0;
`endif

   // Little-endian byte lanes: addr[0]=0 is [7:0], addr[0]=1 is [15:8].
   assign merge_word_d = sel_hi_q ? {sb_byte_q, mem_read_data[7:0]}
                                  : {mem_read_data[15:8], sb_byte_q};
   assign load_byte_d  = {8'h00, (sel_hi_q ? mem_read_data[15:8]
                                           : mem_read_data[7:0])};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         mem_read_q   <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         is_lb_q      <= 1'b0;
         sel_hi_q     <= 1'b0;
         sb_byte_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  req_ready_q <= 1'b0;
                  is_lb_q     <= (req_op == OP_LB);
                  sel_hi_q    <= req_addr[0];
                  sb_byte_q   <= req_wdata[7:0];
                  if (misalign_d) begin
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                  end else begin
                     mem_addr_q <= req_addr;
                     case (req_op)
                        OP_SW: begin
                           state_q     <= S_WR;
                           mem_we_q    <= 1'b1;
                           mem_wdata_q <= req_wdata;
                        end
                        OP_SB: begin
                           state_q    <= S_RMW_RD;
                           mem_read_q <= 1'b1;
                        end
                        default: begin
                           state_q    <= S_RD;
                           mem_read_q <= 1'b1;
                        end
                     endcase
                  end
               end
            end
            S_RD: begin
               resp_rdata_q <= is_lb_q ? load_byte_d : mem_read_data;
               mem_read_q   <= 1'b0;
               mem_addr_q   <= '0;
               state_q      <= S_RESP;
               resp_valid_q <= 1'b1;
            end
            S_WR: begin
               mem_we_q     <= 1'b0;
               mem_addr_q   <= '0;
               mem_wdata_q  <= '0;
               state_q      <= S_RESP;
               resp_valid_q <= 1'b1;
            end
            S_RMW_RD: begin
               // Address is held; the strobe swaps from read to write.
               mem_read_q  <= 1'b0;
               mem_we_q    <= 1'b1;
               mem_wdata_q <= merge_word_d;
               state_q     <= S_RMW_WR;
            end
            S_RMW_WR: begin
               mem_we_q     <= 1'b0;
               mem_addr_q   <= '0;
               mem_wdata_q  <= '0;
               state_q      <= S_RESP;
               resp_valid_q <= 1'b1;
            end
            S_RESP: begin
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               req_ready_q  <= 1'b1;
               state_q      <= S_IDLE;
            end
            default: begin
               state_q      <= S_IDLE;
               req_ready_q  <= 1'b1;
               resp_valid_q <= 1'b0;
               resp_err_q   <= 1'b0;
               mem_read_q   <= 1'b0;
               mem_we_q     <= 1'b0;
               mem_addr_q   <= '0;
               mem_wdata_q  <= '0;
            end
         endcase
      end
   end

   assign req_ready       = req_ready_q;
   assign resp_valid      = resp_valid_q;
   assign resp_err        = resp_err_q;
   assign resp_rdata      = resp_rdata_q;
   assign mem_read        = mem_read_q;
   assign mem_write_en    = mem_we_q;
   assign mem_access_addr = mem_addr_q;
   assign mem_write_data  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   localparam logic [1:0] LW = 2'b00;
   localparam logic [1:0] SW = 2'b01;
   localparam logic [1:0] LB = 2'b10;
   localparam logic [1:0] SB = 2'b11;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic [15:0] resp_rdata;
   logic        resp_err;
   logic [15:0] mem_access_addr;
   logic [15:0] mem_write_data;
   logic        mem_read;
   logic        mem_write_en;
   logic [15:0] mem_read_data;

   int checks;
   int failures;
   int overlap_cnt;

   logic [15:0] mem [256];

   load_store_unit #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
      .mem_read(mem_read), .mem_write_en(mem_write_en),
      .mem_read_data(mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: combinational read, write at posedge while strobed.
   assign mem_read_data = mem_read ? mem[mem_access_addr[8:1]] : 16'h0000;
   always @(posedge clk) if (mem_write_en) mem[mem_access_addr[8:1]] <= mem_write_data;

   always @(negedge clk) if (mem_read && mem_write_en) overlap_cnt++;

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wdata);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
      step();
      req_valid = 1'b0; req_op = 2'b00; req_addr = 16'hFFFF; req_wdata = 16'hFFFF;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
      checks++; if (resp_rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", resp_rdata); end
      checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", resp_err); end
      checks++; if ({mem_read, mem_write_en} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {mem_read, mem_write_en}); end
      checks++; if ({mem_access_addr, mem_write_data} !== 32'h0) begin failures++; $display("FAIL reset_mem_bus got=%h exp=0", {mem_access_addr, mem_write_data}); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_sw_lw();
      issue(SW, 16'h0010, 16'hBEEF);
      checks++; if ({mem_read, mem_write_en} !== 2'b01) begin failures++; $display("FAIL sw_strobe got=%b exp=01", {mem_read, mem_write_en}); end
      checks++; if (mem_access_addr !== 16'h0010 || mem_write_data !== 16'hBEEF) begin failures++; $display("FAIL sw_bus got=%h/%h exp=0010/beef", mem_access_addr, mem_write_data); end
      step();
      checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin failures++; $display("FAIL sw_resp got=%b%b exp=10", resp_valid, resp_err); end
      checks++; if ({mem_read, mem_write_en} !== 2'b00 || mem_access_addr !== 16'h0) begin failures++; $display("FAIL sw_resp_idle_bus got=%b%b/%h exp=00/0000", mem_read, mem_write_en, mem_access_addr); end
      step();
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL sw_back_idle got=%b%b exp=01", resp_valid, req_ready); end
      checks++; if (mem[8] !== 16'hBEEF) begin failures++; $display("FAIL sw_mem got=%h exp=beef", mem[8]); end
      issue(LW, 16'h0010, 16'h0000);
      checks++; if ({mem_read, mem_write_en} !== 2'b10 || mem_access_addr !== 16'h0010) begin failures++; $display("FAIL lw_strobe got=%b%b/%h exp=10/0010", mem_read, mem_write_en, mem_access_addr); end
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL lw_early_resp got=%b exp=0", resp_valid); end
      step();
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 16'hBEEF) begin failures++; $display("FAIL lw_resp got=%b/%h exp=1/beef", resp_valid, resp_rdata); end
      step();
   endtask

   task automatic test_sb_lb();
      issue(SB, 16'h0011, 16'hAA42);
      checks++; if ({mem_read, mem_write_en} !== 2'b10 || mem_access_addr !== 16'h0011) begin failures++; $display("FAIL sb_rd got=%b%b/%h exp=10/0011", mem_read, mem_write_en, mem_access_addr); end
      step();
      checks++; if ({mem_read, mem_write_en} !== 2'b01 || mem_write_data !== 16'h42EF) begin failures++; $display("FAIL sb_wr got=%b%b/%h exp=01/42ef", mem_read, mem_write_en, mem_write_data); end
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL sb_early_resp got=%b exp=0", resp_valid); end
      step();
      checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin failures++; $display("FAIL sb_resp got=%b%b exp=10", resp_valid, resp_err); end
      checks++; if (resp_rdata !== 16'hBEEF) begin failures++; $display("FAIL sb_rdata_held got=%h exp=beef", resp_rdata); end
      step();
      checks++; if (mem[8] !== 16'h42EF) begin failures++; $display("FAIL sb_mem got=%h exp=42ef", mem[8]); end
      issue(LB, 16'h0011, 16'h0000); step();
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 16'h0042) begin failures++; $display("FAIL lb_hi got=%b/%h exp=1/0042", resp_valid, resp_rdata); end
      step();
      issue(LB, 16'h0010, 16'h0000); step();
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 16'h00EF) begin failures++; $display("FAIL lb_lo got=%b/%h exp=1/00ef", resp_valid, resp_rdata); end
      step();
      issue(SB, 16'h0010, 16'h1233); step(); step(); step();
      checks++; if (mem[8] !== 16'h4233) begin failures++; $display("FAIL sb_lo_mem got=%h exp=4233", mem[8]); end
   endtask

   task automatic test_back_to_back();
      int acc_idx[$];
      int resp_cnt;
      issue(SW, 16'h0020, 16'h1234); step(); step();
      resp_cnt = 0;
      req_valid = 1'b1; req_op = LW; req_addr = 16'h0020; req_wdata = 16'h0000;
      for (int i = 0; i < 12; i++) begin
         if (req_ready) acc_idx.push_back(i);
         if (resp_valid) begin
            resp_cnt++;
            checks++; if (resp_rdata !== 16'h1234) begin failures++; $display("FAIL b2b_rdata cyc=%0d got=%h exp=1234", i, resp_rdata); end
         end
         step();
      end
      req_valid = 1'b0;
      step(); step(); step();
      checks++; if (acc_idx.size() != 4) begin failures++; $display("FAIL b2b_accept_count got=%0d exp=4", acc_idx.size()); end
      for (int k = 1; k < acc_idx.size(); k++) begin
         checks++; if (acc_idx[k] - acc_idx[k-1] != 3) begin failures++; $display("FAIL b2b_spacing got=%0d exp=3", acc_idx[k] - acc_idx[k-1]); end
      end
      checks++; if (resp_cnt != 4) begin failures++; $display("FAIL b2b_resp_count got=%0d exp=4", resp_cnt); end
      checks++; if (overlap_cnt != 0) begin failures++; $display("FAIL strobe_overlap got=%0d exp=0", overlap_cnt); end
   endtask

   task automatic test_misalign();
      issue(SW, 16'h0021, 16'h5555);
`ifdef LSU_ALIGN_CHECK_EN
      checks++; if ({mem_read, mem_write_en} !== 2'b00) begin failures++; $display("FAIL mis_no_strobe got=%b%b exp=00", mem_read, mem_write_en); end
      checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin failures++; $display("FAIL mis_err got=%b%b exp=11", resp_valid, resp_err); end
      checks++; if (resp_rdata !== 16'h1234) begin failures++; $display("FAIL mis_rdata_held got=%h exp=1234", resp_rdata); end
      step();
      checks++; if (resp_err !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL mis_clear got=%b%b exp=01", resp_err, req_ready); end
      checks++; if (mem[16] !== 16'h1234) begin failures++; $display("FAIL mis_mem got=%h exp=1234", mem[16]); end
`else
      checks++; if ({mem_read, mem_write_en} !== 2'b01 || mem_access_addr !== 16'h0021) begin failures++; $display("FAIL mis_wr got=%b%b/%h exp=01/0021", mem_read, mem_write_en, mem_access_addr); end
      step();
      checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin failures++; $display("FAIL mis_resp got=%b%b exp=10", resp_valid, resp_err); end
      step();
      checks++; if (mem[16] !== 16'h5555) begin failures++; $display("FAIL mis_mem got=%h exp=5555", mem[16]); end
      issue(LW, 16'h0021, 16'h0000); step();
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 16'h5555) begin failures++; $display("FAIL mis_lw got=%b/%h exp=1/5555", resp_valid, resp_rdata); end
      step();
`endif
   endtask

   task automatic test_reset_mid_sb();
      int seen;
      issue(SW, 16'h0040, 16'hCAFE); step(); step();
      issue(SB, 16'h0040, 16'h0011);
      checks++; if (mem_read !== 1'b1) begin failures++; $display("FAIL rst_sb_in_rmw_rd got=%b exp=1", mem_read); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (req_ready !== 1'b1 || {mem_read, mem_write_en} !== 2'b00 || resp_valid !== 1'b0) begin failures++; $display("FAIL rst_sb_idle got=%b%b%b%b exp=1000", req_ready, mem_read, mem_write_en, resp_valid); end
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (resp_valid || mem_write_en) seen++;
         step();
      end
      checks++; if (seen != 0) begin failures++; $display("FAIL rst_sb_activity got=%0d exp=0", seen); end
      checks++; if (mem[32] !== 16'hCAFE) begin failures++; $display("FAIL rst_sb_mem got=%h exp=cafe", mem[32]); end
      issue(LW, 16'h0040, 16'h0000); step();
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 16'hCAFE) begin failures++; $display("FAIL rst_sb_recover got=%b/%h exp=1/cafe", resp_valid, resp_rdata); end
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; failures = 0; overlap_cnt = 0;
      rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = 16'h0000; req_wdata = 16'h0000;
      #1;
      test_reset();
      test_sw_lw();
      test_sb_lb();
      test_back_to_back();
      test_misalign();
      test_reset_mid_sb();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
